crossing_sequencer: RTL

//  Master FSM for the level-crossing train controller. Consumes synchronized one-cycle sensor pulses,

---
 rtl/crossing_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/crossing_sequencer.sv
// Master sequencer for the level-crossing controller: sensor pulses in, measurement/predictor/timer
// strobes and warn/gate/fault out. Optional predictor watchdog via CROSSING_PRED_TIMEOUT_EN.
module crossing_sequencer #(
  parameter logic [18:0] T_DEFAULT    = 19'd5000,
  parameter logic [18:0] T_MIN        = 19'd64,
  parameter int          HOLD_CYCLES  = 16,
  parameter int          PRED_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sens,
  output logic        meas_clr,
  output logic        meas_en,
  input  logic [14:0] meas_val,
  output logic        pred_start,
  input  logic [18:0] pred_time,
  input  logic        pred_done,
  output logic        tmr_load,
  output logic [18:0] tmr_val,
  input  logic        tmr_expired,
  output logic        warn,
  output logic        gate_close,
  output logic        fault,
  output logic [3:0]  present_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    MEASURE   = 4'd1,
    PREDICT   = 4'd2,
    ARM       = 4'd3,
    COUNTDOWN = 4'd4,
    CROSSING  = 4'd5,
    HOLD      = 4'd6,
    FAULT     = 4'd7
  } state_e;

  localparam int          HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [18:0] T_FALLBK = (T_DEFAULT < T_MIN) ? T_MIN : T_DEFAULT;

  state_e          state_q, state_d;
  logic            first_q;
  logic            fault_q, fault_d;
  logic [18:0]     tmr_val_q, tmr_val_d;
  logic [14:0]     meas_q, meas_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic s1, s2, s_ent, s_ext, sat;
  logic [18:0] pred_floor;

  assign s1         = sens[0];
  assign s2         = sens[1];
  assign s_ent      = sens[2] | sens[3];
  assign s_ext      = sens[4] | sens[5];
  assign sat        = (meas_q == 15'h7FFF);
  assign pred_floor = (pred_time < T_MIN) ? T_MIN : pred_time;

`ifdef CROSSING_PRED_TIMEOUT_EN
  localparam int TW = $clog2(PRED_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pred_tmo;

  assign tcnt_d   = (state_q == PREDICT) ? tcnt_q + TW'(1) : '0;
  assign pred_tmo = (tcnt_q == TW'(PRED_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    tmr_val_d = tmr_val_q;
    meas_d    = meas_q;
    hold_d    = '0;
    // Entry sensors outrank exit, which outrank S2 and S1; S1 only matters in IDLE.
    unique case (state_q)
      IDLE: begin
        if (s_ent || s_ext) state_d = FAULT;
        else if (s1)        state_d = MEASURE;
      end
      MEASURE: begin
        if (s_ent)      state_d = CROSSING;
        else if (s_ext) state_d = FAULT;
        else if (s2) begin
          state_d = PREDICT;
          meas_d  = meas_val;
        end
      end
      PREDICT: begin
        if (s_ent)      state_d = CROSSING;
        else if (s_ext) state_d = FAULT;
        else if (sat) begin
          state_d   = ARM;
          tmr_val_d = T_FALLBK;
        end else if (pred_done) begin
          state_d   = ARM;
          tmr_val_d = pred_floor;
        end
`ifdef CROSSING_PRED_TIMEOUT_EN
        else if (pred_tmo) begin
          state_d   = ARM;
          tmr_val_d = T_FALLBK;
          fault_d   = 1'b1;
        end
`endif
      end
      ARM: begin
        if (s_ent)      state_d = CROSSING;
        else if (s_ext) state_d = FAULT;
        else            state_d = COUNTDOWN;
      end
      COUNTDOWN: begin
        // An early entry sensor means a faster train than predicted: close immediately.
        if (s_ent || tmr_expired) state_d = CROSSING;
        else if (s_ext)           state_d = FAULT;
      end
      CROSSING: begin
        if (!s_ent && s_ext) state_d = HOLD;
      end
      HOLD: begin
        if (s_ent)                                state_d = CROSSING;
        else if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
        else                                      hold_d  = hold_q + HW'(1);
      end
      FAULT: begin
        if (!s_ent && s_ext) state_d = HOLD;
      end
      default: state_d = FAULT;
    endcase
    if (state_d == FAULT)     fault_d = 1'b1;
    else if (state_d == IDLE) fault_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      fault_q   <= 1'b0;
      tmr_val_q <= '0;
      meas_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= (state_d != state_q);
      fault_q   <= fault_d;
      tmr_val_q <= tmr_val_d;
      meas_q    <= meas_d;
      hold_q    <= hold_d;
    end

  always_comb begin
    meas_clr      = (state_q == MEASURE) && first_q;
    meas_en       = (state_q == MEASURE);
    pred_start    = (state_q == PREDICT) && first_q && !sat;
    tmr_load      = (state_q == ARM);
    tmr_val       = tmr_val_q;
    warn          = (state_q == ARM) || (state_q == COUNTDOWN) || (state_q == CROSSING) ||
                    (state_q == HOLD) || (state_q == FAULT);
    gate_close    = (state_q == CROSSING) || (state_q == HOLD) || (state_q == FAULT);
    fault         = fault_q;
    present_state = state_q;
  end

endmodule
